display_sequencer: RTL

Avalon-MM slave that sequences words onto the 32-bit hex/seven-segment display export of the PCIe host system. The host, through the PCIe BAR bridge, pushes display words into an on-chip FIFO. The block shows each word for a programmable dwell time, optionally loops the queue, and raises an interrupt on drain or overflow. It sits between the PCIe-to-Avalon bridge and the `hexport` export, replacing a bare output PIO.

---
 rtl/display_sequencer_if.sv | 36 +++
 rtl/display_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer_if.sv
// ---------------------------------------------------------------------------
// display_sequencer_if
//
// Avalon-MM slave bus between the PCIe-to-Avalon bridge (master) and
// display_sequencer (slave). Clock and reset are not part of this interface.
//
// Signals:
//   address    [2:0]  word register select
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data, latency 1
// ---------------------------------------------------------------------------
interface display_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/display_sequencer.sv
// ---------------------------------------------------------------------------
// display_sequencer
//
// Avalon-MM slave that queues display words written by the host and shows
// each one on the hex/seven-segment export for a programmable dwell time.
// The queue can optionally be looped, and an interrupt is raised on drain
// (DONE) or on overflow (OVF).
//
// Register map (word addresses):
//   0 DATA    (W)     push writedata onto the FIFO tail
//   1 DWELL   (R/W)   dwell count in clk cycles, 0 behaves as 1
//   2 CTRL    (R/W)   bit0 EN, bit1 LOOP, bit2 IRQ_EN, bit31 FLUSH (self-clearing)
//   3 STATUS  (R/W1C) [7:0] level, bit8 empty, bit9 full, bit16 OVF, bit17 DONE
//   4 CURRENT (R)     value currently on out_port
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (display_sequencer_if.slave)
//   out_port  displayed word, to the hex decoders
//   busy      high whenever the sequencer is not IDLE
//   irq       level interrupt, IRQ_EN & (OVF | DONE)
// ---------------------------------------------------------------------------
module display_sequencer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DWELL_RST = 32'd50000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    display_sequencer_if.slave   bus,
    output logic [31:0]          out_port,
    output logic                 busy,
    output logic                 irq
);

    localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            LW         = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DWELL   = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_CURRENT = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic [31:0]   dwell;
    logic [31:0]   counter;
    logic          ctrl_en;
    logic          ctrl_loop;
    logic          ctrl_irq_en;
    logic          ovf;
    logic          done;

    logic          wr_req;
    logic          rd_req;
    logic          data_wr;
    logic          dwell_wr;
    logic          ctrl_wr;
    logic          status_wr;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_full;
    logic          load_go;
    logic          pop;
    logic          loop_copy;
    logic          push_ok;
    logic          push_drop;
    logic          done_set;
    logic          ovf_nxt;
    logic          done_nxt;
    logic          irq_en_nxt;
    logic [31:0]   head_word;
    logic [31:0]   dwell_load;
    logic [31:0]   status_word;

    // Bus decode and the FIFO strobes shared by the FSM and the datapath.
    // A LOAD with LOOP set recirculates the head word instead of popping it,
    // so only a non-loop pop frees a slot for a simultaneous host push.
    always_comb begin
        wr_req      = bus.chipselect & ~bus.write_n;
        rd_req      = bus.chipselect & bus.write_n;
        data_wr     = wr_req & (bus.address == ADDR_DATA);
        dwell_wr    = wr_req & (bus.address == ADDR_DWELL);
        ctrl_wr     = wr_req & (bus.address == ADDR_CTRL);
        status_wr   = wr_req & (bus.address == ADDR_STATUS);
        flush       = ctrl_wr & bus.writedata[31];

        fifo_empty  = (level == '0);
        fifo_full   = (level == FULL_LEVEL);
        head_word   = fifo_mem[rd_ptr];
        dwell_load  = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;

        load_go     = (state == LOAD) & ~fifo_empty & ~flush;
        pop         = load_go & ~ctrl_loop;
        loop_copy   = load_go & ctrl_loop;
        push_ok     = data_wr & (~fifo_full | pop);
        push_drop   = data_wr & ~push_ok;

        done_set    = (state == SHOW) & ctrl_en & (counter == 32'd0)
                    & fifo_empty & ~ctrl_loop & ~flush;

        // Sticky flags: a set in the same cycle as a W1C clear wins.
        ovf_nxt     = (ovf  & ~(status_wr & bus.writedata[16])) | push_drop;
        done_nxt    = (done & ~(status_wr & bus.writedata[17])) | done_set;
        irq_en_nxt  = ctrl_wr ? bus.writedata[2] : ctrl_irq_en;

        status_word = {14'd0, done, ovf, 6'd0, fifo_full, fifo_empty, 8'(level)};
    end

    // Sequencer FSM. FLUSH overrides everything and parks in IDLE while
    // out_port keeps the word that was showing. busy is registered together
    // with the state so it reflects the state of the current cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            counter  <= 32'd0;
            out_port <= 32'd0;
            busy     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_en && !fifo_empty) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_go) begin
                        out_port <= head_word;
                        counter  <= dwell_load;
                        state    <= SHOW;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SHOW: begin
                    if (!ctrl_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (counter == 32'd0) begin
                        if (!fifo_empty) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage. A looping LOAD writes the head word back at the tail;
    // a host push in that same cycle lands in the slot after it.
    always_ff @(posedge clk) begin
        if (loop_copy) begin
            fifo_mem[wr_ptr] <= head_word;
            if (push_ok) begin
                fifo_mem[wr_ptr + PW'(1)] <= bus.writedata;
            end
        end else if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.writedata;
        end
    end

    // FIFO pointers and level. Pointers wrap naturally because DEPTH is a
    // power of two; level needs one extra bit to represent a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (pop || loop_copy) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (loop_copy && push_ok) begin
                wr_ptr <= wr_ptr + PW'(2);
            end else if (loop_copy || push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push_ok) begin
                level <= level - LW'(1);
            end
        end
    end

    // Control/status registers and the interrupt. irq is built from the
    // next-state flag values so it lines up with the flags it reports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell       <= DWELL_RST;
            ctrl_en     <= 1'b0;
            ctrl_loop   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (dwell_wr) begin
                dwell <= bus.writedata;
            end
            if (ctrl_wr) begin
                ctrl_en   <= bus.writedata[0];
                ctrl_loop <= bus.writedata[1];
            end
            ctrl_irq_en <= irq_en_nxt;
            ovf         <= ovf_nxt;
            done        <= done_nxt;
            irq         <= irq_en_nxt & (ovf_nxt | done_nxt);
        end
    end

    // Registered read port; returns register state as of the read edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 32'd0;
        end else if (rd_req) begin
            case (bus.address)
                ADDR_DWELL:   bus.readdata <= dwell;
                ADDR_CTRL:    bus.readdata <= {29'd0, ctrl_irq_en, ctrl_loop, ctrl_en};
                ADDR_STATUS:  bus.readdata <= status_word;
                ADDR_CURRENT: bus.readdata <= out_port;
                default:      bus.readdata <= 32'd0;
            endcase
        end
    end

endmodule
